mult_div_unit: RTL and testbench

- Multiply/divide unit with HI/LO registers, directly downstream of the register file in the EX stage.
- Consumes the two register read operands for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Models fixed multi-cycle latency with a countdown and exposes Busy so hazard logic can stall MFHI/MFLO and back-to-back multiply/divide operations.
- HI/LO are architectural state owned by this block.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_arith.sv | 82 ++++++++
 rtl/mult_div_unit.sv | 102 ++++++++++
 tb/tb_mult_div_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and default latencies for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Default busy lengths; hazard/stall logic sizes its interlock from these too
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  // Divide ops share the upper encoding bit
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath producing HI/LO results
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  Op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] s_quo_u;
  logic [31:0] s_rem_u;
  logic [31:0] u_quo;
  logic [31:0] u_rem;
  logic [31:0] b_safe;
  logic [31:0] bm_safe;

  // Sign-extended operands give the signed product in the low 64 bits
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed divide runs on magnitudes; a zero divisor is steered to 1 so no X appears
  assign a_neg   = A[31];
  assign b_neg   = B[31];
  assign a_mag   = a_neg ? (~A + 32'd1) : A;
  assign b_mag   = b_neg ? (~B + 32'd1) : B;
  assign b_safe  = (B == 32'd0) ? 32'd1 : B;
  assign bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign s_quo_u = a_mag / bm_safe;
  assign s_rem_u = a_mag % bm_safe;
  assign u_quo   = A / b_safe;
  assign u_rem   = A % b_safe;

  // Result select, including divide-by-zero and the signed overflow corner
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op_e'(Op))
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_lo = (a_neg ^ b_neg) ? (~s_quo_u + 32'd1) : s_quo_u;
          res_hi = a_neg ? (~s_rem_u + 32'd1) : s_rem_u;
        end
      end
      OP_DIVU: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = u_rem;
          res_lo = u_quo;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - fixed-latency multiply/divide unit owning the HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = mdu_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = mdu_pkg::DIV_CYCLES
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        WeHi,
  input  logic        WeLo,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d;
  logic [31:0]      hi_d, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic [31:0]      arith_hi, arith_lo;

  mdu_arith u_arith (
    .A      (A),
    .B      (B),
    .Op     (Op),
    .res_hi (arith_hi),
    .res_lo (arith_lo)
  );

  // State, countdown, pending result and HI/LO registers; reset discards everything
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      Busy     <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      Busy     <= busy_d;
      HI       <= hi_d;
      LO       <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // Next-state: launch latches operands' result once, RUN counts down and commits at zero
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = Busy;
    hi_d     = HI;
    lo_d     = LO;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          res_hi_d = arith_hi;
          res_lo_d = arith_lo;
          cnt_d    = op_is_div(Op) ? DIV_LOAD : MULT_LOAD;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          if (WeHi) hi_d = A;
          if (WeLo) lo_d = A;
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        WeHi;
  logic        WeLo;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .WeHi  (WeHi),
    .WeLo  (WeLo),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural definition of each op
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      2'b00: begin
        q = sa * sb;
        res = q;
      end
      2'b01: begin
        p = ua * ub;
        res = p;
      end
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit wehi_with_start, input bit inj_start, input bit inj_we,
                        input string tag);
    logic [63:0] res;
    int          n;
    int          lat;
    res = model(op, a, b);
    lat = op[1] ? DIV_CYCLES : MULT_CYCLES;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b; WeHi = wehi_with_start; WeLo = 1'b0;
    @(negedge Clk);
    Start = 1'b0; WeHi = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (Busy === 1'b1 && n < 64) begin
      check({tag, " hold"}, {HI, LO}, {exp_hi, exp_lo});
      n++;
      Start = 1'b0; WeHi = 1'b0; WeLo = 1'b0;
      if (n == 2 && inj_start) begin
        Start = 1'b1; Op = 2'($urandom); A = $urandom; B = $urandom;
      end
      if (n == 2 && inj_we) begin
        WeHi = 1'b1; WeLo = 1'b1; A = $urandom;
      end
      @(negedge Clk);
    end
    Start = 1'b0; WeHi = 1'b0; WeLo = 1'b0;
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    check({tag, " busy_cycles"}, 64'(n), 64'(lat));
    check({tag, " hi_lo"}, {HI, LO}, res);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    Rst = 1'b1; Start = 1'b0; Op = 2'b00; A = 32'd0; B = 32'd0; WeHi = 1'b0; WeLo = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    check("reset busy", {63'd0, Busy}, 64'd0);
    check("reset hi_lo", {HI, LO}, 64'd0);

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0, "mult_neg");
    check("mult_neg literal", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0, "multu");
    check("multu literal", {HI, LO}, {32'h0000_0001, 32'hFFFF_FFFE});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, "div_neg");
    check("div_neg literal", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, "divu_zero");
    check("divu_zero literal", {HI, LO}, {32'd7, 32'hFFFF_FFFF});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, "div_ovf_restart");
    check("div_ovf literal", {HI, LO}, {32'd0, 32'h8000_0000});

    // MTHI alone, then MTHI+MTLO together, from IDLE
    @(negedge Clk);
    WeHi = 1'b1; A = 32'h1234_5678;
    @(negedge Clk);
    WeHi = 1'b0;
    exp_hi = 32'h1234_5678;
    check("mthi", {HI, LO}, {exp_hi, exp_lo});
    WeHi = 1'b1; WeLo = 1'b1; A = 32'hCAFE_F00D;
    @(negedge Clk);
    WeHi = 1'b0; WeLo = 1'b0;
    exp_hi = 32'hCAFE_F00D; exp_lo = 32'hCAFE_F00D;
    check("mthi_mtlo", {HI, LO}, {exp_hi, exp_lo});

    run_op(2'b01, 32'h0000_0100, 32'h0000_0010, 1'b0, 1'b0, 1'b1, "we_in_run");
    run_op(2'b00, 32'h1234_5678, 32'd2, 1'b1, 1'b0, 1'b0, "start_with_mthi");
    check("start_with_mthi literal", {HI, LO}, {32'd0, 32'h2468_ACF0});

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    // Reset on the third busy cycle of a multiply aborts it with no late commit
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    check("abort busy1", {63'd0, Busy}, 64'd1);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    check("abort busy", {63'd0, Busy}, 64'd0);
    check("abort hi_lo", {HI, LO}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("abort no_late_write", {HI, LO}, 64'd0);
      check("abort stays_idle", {63'd0, Busy}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
